// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed 6-digit seven-segment bus, debounces each digit,
// decodes the glyphs back to hex nibbles and delivers 24-bit frames over valid/ready.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [6:0]  seg_in,
    input  logic [5:0]  digit_sel,
    input  logic        value_ready,
    output logic [23:0] value,
    output logic [5:0]  digit_err,
    output logic        value_valid,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);

    // Returns {err, nibble}; illegal glyphs decode to nibble 0 with err set.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b0000001: res = 5'h00;
            7'b1001111: res = 5'h01;
            7'b0010010: res = 5'h02;
            7'b0000110: res = 5'h03;
            7'b1001100: res = 5'h04;
            7'b0100100: res = 5'h05;
            7'b0100000: res = 5'h06;
            7'b0001111: res = 5'h07;
            7'b0000000: res = 5'h08;
            7'b0000100: res = 5'h09;
            7'b0001000: res = 5'h0A;
            7'b1100000: res = 5'h0B;
            7'b0110001: res = 5'h0C;
            7'b1000010: res = 5'h0D;
            7'b0110000: res = 5'h0E;
            7'b0111000: res = 5'h0F;
            default:    res = 5'h10;
        endcase
        return res;
    endfunction

    function automatic logic is_one_hot(input logic [5:0] sel);
        return (sel != 6'd0) && ((sel & (sel - 6'd1)) == 6'd0);
    endfunction

    logic [6:0]       s_seg_r;
    logic [5:0]       s_sel_r;
    logic [CNT_W-1:0] cnt_r;
    logic [23:0]      slot_nib_r;
    logic [5:0]       slot_err_r;
    logic [5:0]       captured_r;

    logic             match_s;
    logic             accept_s;
    logic             full_s;
    logic             transfer_s;
    logic             store_s;
    logic [4:0]       dec_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [23:0]      slot_nib_next_s;
    logic [5:0]       slot_err_next_s;
    logic [5:0]       captured_next_s;
    logic             overrun_next_s;

    // Debounce, accept detection, slot buffer update and frame hand-off decision.
    always_comb begin
        match_s         = ({digit_sel, seg_in} == {s_sel_r, s_seg_r});
        dec_s           = decode_glyph(s_seg_r);
        cnt_next_s      = CNT_W'(1);
        slot_nib_next_s = slot_nib_r;
        slot_err_next_s = slot_err_r;
        captured_next_s = captured_r;

        if (match_s) begin
            if (cnt_r >= STABLE_MAX) begin
                cnt_next_s = STABLE_MAX;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_next_s = CNT_W'(1);
        end

        accept_s   = match_s && (cnt_r == STABLE_PRE) && is_one_hot(s_sel_r);
        full_s     = (captured_r == 6'b111111);
        transfer_s = full_s && (!value_valid || value_ready);
        // A stalled full buffer drops the accept; a transferring one takes it fresh.
        store_s    = accept_s && (!full_s || transfer_s);
        overrun_next_s = overrun | (accept_s && full_s && !transfer_s);

        if (transfer_s) begin
            captured_next_s = 6'b000000;
        end else begin
            captured_next_s = captured_r;
        end

        for (int i = 0; i < 6; i++) begin
            if (store_s && s_sel_r[i]) begin
                slot_nib_next_s[4*i +: 4] = dec_s[3:0];
                slot_err_next_s[i]        = dec_s[4];
                captured_next_s[i]        = 1'b1;
            end else begin
                slot_nib_next_s[4*i +: 4] = slot_nib_next_s[4*i +: 4];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_seg_r     <= 7'd0;
            s_sel_r     <= 6'd0;
            cnt_r       <= '0;
            slot_nib_r  <= 24'd0;
            slot_err_r  <= 6'd0;
            captured_r  <= 6'd0;
            value       <= 24'd0;
            digit_err   <= 6'd0;
            value_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            s_seg_r    <= seg_in;
            s_sel_r    <= digit_sel;
            cnt_r      <= cnt_next_s;
            slot_nib_r <= slot_nib_next_s;
            slot_err_r <= slot_err_next_s;
            captured_r <= captured_next_s;
            overrun    <= overrun_next_s;
            if (transfer_s) begin
                value       <= slot_nib_r;
                digit_err   <= slot_err_r;
                value_valid <= 1'b1;
            end else if (value_valid && value_ready) begin
                value_valid <= 1'b0;
            end else begin
                value_valid <= value_valid;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder.
module tb_seg_scan_decoder;

    logic        clock = 1'b0;
    logic        resetn;
    logic [6:0]  seg_in;
    logic [5:0]  digit_sel;
    logic        value_ready;
    logic [23:0] value;
    logic [5:0]  digit_err;
    logic        value_valid;
    logic        overrun;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_cnt   = 0;
    int          hs_base;
    logic [23:0] hs_value = 24'd0;
    logic [5:0]  hs_err   = 6'd0;
    logic [6:0]  glyph [0:15];

    localparam logic [6:0] BLANK = 7'b1111111;

    seg_scan_decoder #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .clock(clock), .resetn(resetn), .seg_in(seg_in), .digit_sel(digit_sel),
        .value_ready(value_ready), .value(value), .digit_err(digit_err),
        .value_valid(value_valid), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Record every completed handshake.
    always @(posedge clock) begin
        if (resetn && value_valid && value_ready) begin
            hs_cnt   <= hs_cnt + 1;
            hs_value <= value;
            hs_err   <= digit_err;
        end
    end

    task automatic show_raw(input logic [5:0] sel, input logic [6:0] g, input int n);
        digit_sel = sel;
        seg_in    = g;
        repeat (n) @(negedge clock);
    endtask

    task automatic show(input int d, input logic [6:0] g, input int n);
        logic [5:0] one;
        one = 6'd1;
        show_raw(one << d, g, n);
    endtask

    task automatic idle(input int n);
        show_raw(6'd0, BLANK, n);
    endtask

    task automatic test_reset;
        resetn = 1'b0; seg_in = BLANK; digit_sel = 6'd0; value_ready = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({value, digit_err, value_valid, overrun} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got value=%h err=%b valid=%b ovr=%b, want all 0",
                     value, digit_err, value_valid, overrun);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_clean_frame;
        hs_base = hs_cnt;
        for (int d = 0; d < 6; d++) show(d, glyph[d+1], 4);
        n_checks++;
        if (value_valid !== 1'b0) begin
            n_fail++; $display("FAIL clean_latency_early: valid=%b want 0", value_valid);
        end
        idle(1);
        n_checks++;
        if (value_valid !== 1'b1 || value !== 24'h654321 || digit_err !== 6'd0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_frame: valid=%b value=%h err=%b ovr=%b, want 1 654321 000000 0",
                     value_valid, value, digit_err, overrun);
        end
        idle(1);
        n_checks++;
        if (value_valid !== 1'b0) begin
            n_fail++; $display("FAIL clean_valid_drop: valid=%b want 0", value_valid);
        end
        idle(3);
        n_checks++;
        if (hs_cnt - hs_base !== 1) begin
            n_fail++; $display("FAIL clean_pulses: got %0d handshakes want 1", hs_cnt - hs_base);
        end
    endtask

    task automatic test_glitch;
        hs_base = hs_cnt;
        show(0, glyph[7], 3);
        idle(1);
        for (int d = 1; d < 6; d++) show(d, glyph[8], 4);
        idle(8);
        n_checks++;
        if (value_valid !== 1'b0 || hs_cnt !== hs_base) begin
            n_fail++;
            $display("FAIL glitch_reject: valid=%b handshakes=%0d, want 0 and 0",
                     value_valid, hs_cnt - hs_base);
        end
        show(0, glyph[7], 20);
        idle(3);
        n_checks++;
        if (hs_cnt - hs_base !== 1 || hs_value !== 24'h888887 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_long_hold: handshakes=%0d value=%h ovr=%b, want 1 888887 0",
                     hs_cnt - hs_base, hs_value, overrun);
        end
    endtask

    task automatic test_illegal_glyph;
        hs_base = hs_cnt;
        for (int d = 0; d < 6; d++) show(d, (d == 2) ? BLANK : glyph[8], 4);
        idle(3);
        n_checks++;
        if (hs_cnt - hs_base !== 1 || hs_value !== 24'h888088 || hs_err !== 6'b000100) begin
            n_fail++;
            $display("FAIL illegal_glyph: handshakes=%0d value=%h err=%b, want 1 888088 000100",
                     hs_cnt - hs_base, hs_value, hs_err);
        end
    endtask

    task automatic test_bad_select;
        hs_base = hs_cnt;
        show_raw(6'b000011, glyph[5], 10);
        show_raw(6'b000000, glyph[5], 10);
        for (int d = 1; d < 6; d++) show(d, glyph[5], 4);
        idle(6);
        n_checks++;
        if (value_valid !== 1'b0 || hs_cnt !== hs_base) begin
            n_fail++;
            $display("FAIL bad_select: valid=%b handshakes=%0d, want 0 and 0",
                     value_valid, hs_cnt - hs_base);
        end
        show(0, glyph[5], 4);
        idle(3);
        n_checks++;
        if (hs_cnt - hs_base !== 1 || hs_value !== 24'h555555) begin
            n_fail++;
            $display("FAIL bad_select_recover: handshakes=%0d value=%h, want 1 555555",
                     hs_cnt - hs_base, hs_value);
        end
    endtask

    task automatic test_backpressure;
        value_ready = 1'b0;
        for (int d = 0; d < 6; d++) show(d, glyph[10], 4);
        for (int d = 0; d < 6; d++) show(d, glyph[11], 4);
        idle(2);
        n_checks++;
        if (value_valid !== 1'b1 || value !== 24'hAAAAAA || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_a: valid=%b value=%h ovr=%b, want 1 aaaaaa 0",
                     value_valid, value, overrun);
        end
        show(0, glyph[1], 4);
        idle(1);
        n_checks++;
        if (overrun !== 1'b1 || value !== 24'hAAAAAA) begin
            n_fail++;
            $display("FAIL bp_overrun: ovr=%b value=%h, want 1 aaaaaa", overrun, value);
        end
        value_ready = 1'b1;
        idle(1);
        n_checks++;
        if (value_valid !== 1'b1 || value !== 24'hBBBBBB || digit_err !== 6'd0) begin
            n_fail++;
            $display("FAIL bp_back_to_back: valid=%b value=%h err=%b, want 1 bbbbbb 000000",
                     value_valid, value, digit_err);
        end
        idle(1);
        n_checks++;
        if (value_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: valid=%b ovr=%b, want 0 1", value_valid, overrun);
        end
    endtask

    task automatic test_reset_mid_frame;
        hs_base = hs_cnt;
        for (int d = 0; d < 3; d++) show(d, glyph[3], 4);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({value, digit_err, value_valid, overrun} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: value=%h err=%b valid=%b ovr=%b, want all 0",
                     value, digit_err, value_valid, overrun);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int d = 3; d < 6; d++) show(d, glyph[9], 4);
        idle(4);
        n_checks++;
        if (value_valid !== 1'b0 || hs_cnt !== hs_base) begin
            n_fail++;
            $display("FAIL reset_stale_capture: valid=%b handshakes=%0d, want 0 and 0",
                     value_valid, hs_cnt - hs_base);
        end
        for (int d = 0; d < 6; d++) show(d, glyph[9], 4);
        idle(3);
        n_checks++;
        if (hs_cnt - hs_base !== 1 || hs_value !== 24'h999999 || hs_err !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_next_frame: handshakes=%0d value=%h err=%b, want 1 999999 000000",
                     hs_cnt - hs_base, hs_value, hs_err);
        end
    endtask

    initial begin
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111; glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
        glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100; glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0000100; glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010; glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;
        test_reset();
        test_clean_frame();
        test_glitch();
        test_illegal_glyph();
        test_bad_select();
        test_backpressure();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
